alu_mul_seq: RTL and testbench
==============================

// Module: alu_mul_seq
// PURPOSE
//  Multi-cycle unsigned N x N -> N multiplier sequencer that sits in front of the datapath ALU.
//  Drives the ALU's operand and op-code inputs and consumes its result and flags (q, zero, paridad, mayor).
//  Uses a shift-and-add algorithm.
//  Produces the low N bits of the product, plus an exact overflow flag (true product >= 2^N).
// PARAMETERS
//  N  16  datapath width; fixed at 16 because ALU 'mayor' (carry) is defined only for bit 16
// PORTS
//  i_clk       in   1  single clock, rising edge
//  i_reset     in   1  synchronous, active-high reset
//  i_start     in   1  start request; sampled only in IDLE
//  i_a         in   N  multiplicand, captured on accepted start
//  i_b         in   N  multiplier, captured on accepted start
//  o_busy      out  1  high from cycle after accepted start through DONE
//  o_done      out  1  one-cycle pulse in DONE state
//  o_product   out  N  product low N bits; valid from o_done, held until next accepted start
//  o_ovf       out  1  overflow; valid with o_done, held like o_product
//  o_alu_a     out  N  to ALU i_a
//  o_alu_b     out  N  to ALU i_b
//  o_alu_ctrl  out  3  to ALU i_control
//  i_alu_q     in   N  from ALU q (combinational, same cycle)
//  i_alu_zero  in   1  from ALU zero
//  i_alu_par   in   1  from ALU paridad (LSB of q)
//  i_alu_mayor in   1  from ALU mayor (carry out of suma)
// BEHAVIOUR
//  Registers: A (multiplicand, shifts left), B (multiplier, shifts right), P (partial product), lost_r, ovf_r.
//  Reset: state=IDLE; A=B=P=0; lost_r=ovf_r=0; o_busy=o_done=o_ovf=0; o_product=0.
//  Reset: o_alu_a=o_alu_b=0; o_alu_ctrl=PASAR_B.
//  Reset mid-operation aborts with no o_done.
//  IDLE: if i_start: A<=i_a, B<=i_b, P<=0, lost_r<=0, ovf_r<=0 -> TEST. Else stay.
//  TEST: ctrl=PASAR_B, alu_b=B.
//    If i_alu_zero -> DONE.
//    Else if lost_r: ovf_r<=1.
//    Then if i_alu_par -> ADD, else -> SHR.
//  ADD: ctrl=SUMA, alu_a=P, alu_b=A; P<=i_alu_q; if i_alu_mayor: ovf_r<=1; -> SHR.
//  SHR: ctrl=SHIFT_D, alu_a=B; B<=i_alu_q; -> SHL.
//  SHL: ctrl=SHIFT_I, alu_a=A; A<=i_alu_q; if A[N-1]: lost_r<=1; -> TEST.
//  DONE: o_done=1, o_product<=P, o_ovf<=ovf_r -> IDLE. o_busy stays 1 in DONE.
//  ALU outputs are combinational from state and registers.
//  In IDLE/DONE: ctrl=PASAR_B, alu_a/alu_b=0.
//  All state updates use ALU results sampled in the same cycle; there are no ALU pipeline stages.
//  Latency: start accepted at edge k -> o_done high in cycle k+L.
//    L = 3*m + popcount(i_b) + 2, where m = index of highest set bit of i_b + 1 (m=0 if i_b=0).
//    Maximum L = 66 (i_b=0xFFFF).
//  i_start while busy: ignored, with no queuing.
//  i_start in the DONE cycle: ignored; it is sampled in the following IDLE cycle.
//  Termination guaranteed: B reaches 0 after at most N SHR steps.
//  Overflow exact: set iff a carry occurs in ADD, or a 1 was shifted out of A while B is still nonzero.
//  ALU codes: SUMA=000, SHIFT_D=001, RESTA=010, SHIFT_I=011, PASAR_B=100. RESTA is unused.
// STRUCTURE
//  Shared package: ALU op-code constants (above); sequencer state encoding IDLE, TEST, ADD, SHR, SHL, DONE
//  (3-bit binary).
//  No sub-module: single FSM + datapath registers. The ALU is instantiated by the parent and wired to o_alu_*/i_alu_*.
//  Bench instantiates alu_mul_seq together with the real ALU.
// TESTING
//  a=5,b=3, start at edge k -> o_done pulse in cycle k+10, o_product=15, o_ovf=0; o_busy high k+1..k+10.
//  a=0x1234,b=0 -> o_done at k+2, o_product=0, o_ovf=0.
//  a=0xFFFF,b=0xFFFF -> o_done at k+66, o_product=0x0001, o_ovf=1.
//  a=0x0100,b=0x0100 -> o_product=0x0000, o_ovf=1 (shift-loss path, no carry).
//  a=0x00FF,b=0x0101 -> o_product=0xFFFF, o_ovf=0 (boundary, no false overflow).
//  Start a=7,b=9; pulse i_start with a=1,b=1 mid-run -> result 63 only.
//    Then i_reset mid-run -> no o_done, all outputs at reset values next cycle.

Source files
------------

// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the shift-and-add multiplier sequencer.
// Holds the datapath width, the ALU op-code constants and the sequencer
// state encoding used by alu_mul_seq and by anything wiring it to the ALU.
package alu_mul_seq_pkg;

  // Width is tied to the ALU: its carry flag ('mayor') exists only for bit 16.
  localparam int N = 16;

  // ALU op-codes as seen on the ALU's i_control input.
  localparam logic [2:0] ALU_SUMA    = 3'b000;
  localparam logic [2:0] ALU_SHIFT_D = 3'b001;
  localparam logic [2:0] ALU_RESTA   = 3'b010;  // not issued by the sequencer
  localparam logic [2:0] ALU_SHIFT_I = 3'b011;
  localparam logic [2:0] ALU_PASAR_B = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TEST = 3'd1,
    S_ADD  = 3'd2,
    S_SHR  = 3'd3,
    S_SHL  = 3'd4,
    S_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned 16x16->16 shift-and-add multiplier that borrows the datapath ALU.
// Latency 3*m + popcount(b) + 2 cycles (m = bit length of b); max 66.
// No queuing: i_start is honoured only in IDLE, ignored while o_busy.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_start, i_a, i_b         start request and operands (captured in IDLE)
//   o_busy, o_done            busy flag, one-cycle completion pulse
//   o_product, o_ovf          low product bits and exact overflow, held
//   o_alu_a/b, o_alu_ctrl     operands and op-code driven to the ALU
//   i_alu_q/zero/par/mayor    combinational ALU result and flags
module alu_mul_seq
  import alu_mul_seq_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_product,
  output logic         o_ovf,
  output logic [N-1:0] o_alu_a,
  output logic [N-1:0] o_alu_b,
  output logic [2:0]   o_alu_ctrl,
  input  logic [N-1:0] i_alu_q,
  input  logic         i_alu_zero,
  input  logic         i_alu_par,
  input  logic         i_alu_mayor
);

  state_e       state_q, state_d;
  logic [N-1:0] a_q, a_d;        // multiplicand, shifts left
  logic [N-1:0] b_q, b_d;        // multiplier, shifts right
  logic [N-1:0] p_q, p_d;        // partial product
  logic         lost_q, lost_d;  // a 1 has been shifted out of A
  logic         ovf_q, ovf_d;    // running overflow
  logic [N-1:0] product_q, product_d;
  logic         ovf_out_q, ovf_out_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      lost_q    <= 1'b0;
      ovf_q     <= 1'b0;
      product_q <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      p_q       <= p_d;
      lost_q    <= lost_d;
      ovf_q     <= ovf_d;
      product_q <= product_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    p_d        = p_q;
    lost_d     = lost_q;
    ovf_d      = ovf_q;
    product_d  = product_q;
    ovf_out_d  = ovf_out_q;
    o_alu_ctrl = ALU_PASAR_B;
    o_alu_a    = '0;
    o_alu_b    = '0;
    o_done     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          a_d     = i_a;
          b_d     = i_b;
          p_d     = '0;
          lost_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_TEST;
        end
      end
      S_TEST: begin
        // Pass B through the ALU to get its zero flag and LSB.
        o_alu_b = b_q;
        if (i_alu_zero) begin
          // P and ovf are final here, so the outputs are loaded on the way
          // into DONE and are already valid while o_done is high.
          product_d = p_q;
          ovf_out_d = ovf_q;
          state_d   = S_DONE;
        end else begin
          // Bits lost from A only matter if B still has work to do.
          if (lost_q) ovf_d = 1'b1;
          state_d = i_alu_par ? S_ADD : S_SHR;
        end
      end
      S_ADD: begin
        o_alu_ctrl = ALU_SUMA;
        o_alu_a    = p_q;
        o_alu_b    = a_q;
        p_d        = i_alu_q;
        if (i_alu_mayor) ovf_d = 1'b1;
        state_d    = S_SHR;
      end
      S_SHR: begin
        o_alu_ctrl = ALU_SHIFT_D;
        o_alu_a    = b_q;
        b_d        = i_alu_q;
        state_d    = S_SHL;
      end
      S_SHL: begin
        o_alu_ctrl = ALU_SHIFT_I;
        o_alu_a    = a_q;
        a_d        = i_alu_q;
        if (a_q[N-1]) lost_d = 1'b1;
        state_d    = S_TEST;
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_busy    = (state_q != S_IDLE);
  assign o_product = product_q;
  assign o_ovf     = ovf_out_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;
  import alu_mul_seq_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a, b;
  logic         busy, done, ovf;
  logic [N-1:0] product;
  logic [N-1:0] alu_a, alu_b, alu_q;
  logic [2:0]   alu_ctrl;
  logic         alu_zero, alu_par, alu_mayor;

  always #5 clk = ~clk;

  alu_mul_seq dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_a(a), .i_b(b),
    .o_busy(busy), .o_done(done), .o_product(product), .o_ovf(ovf),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_ctrl(alu_ctrl),
    .i_alu_q(alu_q), .i_alu_zero(alu_zero), .i_alu_par(alu_par),
    .i_alu_mayor(alu_mayor)
  );

  // Datapath ALU behaviour as seen by the sequencer.
  always_comb begin
    alu_q     = '0;
    alu_mayor = 1'b0;
    case (alu_ctrl)
      3'b000:  {alu_mayor, alu_q} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001:  alu_q = alu_a >> 1;
      3'b010:  alu_q = alu_a - alu_b;
      3'b011:  alu_q = alu_a << 1;
      3'b100:  alu_q = alu_b;
      default: alu_q = '0;
    endcase
  end
  assign alu_zero = (alu_q == '0);
  assign alu_par  = alu_q[0];

  typedef struct {
    logic [N-1:0] prod;
    logic         ovf;
    int           lat;
    int           start_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   passed = 0;
  int   total  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every o_done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("product", product, e.prod);
        check("ovf", ovf, e.ovf);
        check("latency", cyc - e.start_cyc, e.lat);
        check("busy_in_done", busy, 1'b1);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin @(negedge clk); n++; end
    if (sb.size() != 0 || busy) check("drain_timeout", sb.size(), 32'd0);
  endtask

  // Issue a start in IDLE; the cycle it is presented is cycle k-1 relative
  // to the accepting edge, so o_done is seen L cycles later.
  task automatic run(input logic [N-1:0] ia, input logic [N-1:0] ib,
                     input logic [N-1:0] ep, input logic eo, input int el,
                     input bit expect_result);
    exp_t e;
    wait_idle();
    a = ia; b = ib; start = 1'b1;
    e.prod = ep; e.ovf = eo; e.lat = el; e.start_cyc = cyc;
    if (expect_result) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_product", product, 16'h0000);
    check("rst_ovf", ovf, 1'b0);
    check("rst_alu_a", alu_a, 16'h0000);
    check("rst_alu_b", alu_b, 16'h0000);
    check("rst_alu_ctrl", alu_ctrl, 3'b100);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors: a, b, product, ovf, latency.
    run(16'd5,    16'd3,    16'd15,   1'b0, 10, 1'b1);
    run(16'h1234, 16'h0000, 16'h0000, 1'b0, 2,  1'b1);
    run(16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 66, 1'b1);
    run(16'h0100, 16'h0100, 16'h0000, 1'b1, 30, 1'b1);
    run(16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 31, 1'b1);
    drain();
    check("product_held", product, 16'hFFFF);

    // A start pulse while busy must be dropped entirely.
    run(16'd7, 16'd9, 16'd63, 1'b0, 16, 1'b1);
    repeat (4) @(negedge clk);
    a = 16'd1; b = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (20) @(negedge clk);
    check("no_extra_done", sb.size(), 32'd0);
    check("product_after_ignore", product, 16'd63);

    // Reset mid-run aborts with no completion pulse.
    run(16'd7, 16'd9, 16'd0, 1'b0, 0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("idle_after_abort", busy, 1'b0);

    // Sequencer still works after the abort.
    run(16'd12, 16'd4, 16'd48, 1'b0, 12, 1'b1);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
